global_buffer_dp: RTL and testbench

//  Parametrised simple-dual-port global buffer: one write port, one read port, same clock.

---
 rtl/gbuf_pkg.sv | 24 ++
 rtl/gbuf_mem_array.sv | 45 ++++
 rtl/global_buffer_dp.sv | 160 ++++++++++++++++
 tb/tb_global_buffer_dp.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gbuf_pkg.sv
// gbuf_pkg
//  Shared definitions for the global buffer:
//   - sweep FSM state encoding (INIT / IDLE / CLEAR)
//   - default geometry (GBUF_DATA_W, GBUF_DEPTH)
//   - merge(): byte-lane merge used to build a partially strobed word
package gbuf_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    CLEAR = 2'd2
  } gbuf_state_e;

  localparam int GBUF_DATA_W = 32;
  localparam int GBUF_DEPTH  = 256;

  // One byte lane of a strobed write: take the new byte when its strobe is set.
  function automatic logic [7:0] merge(input logic [7:0] old_b,
                                       input logic [7:0] new_b,
                                       input logic       strb);
    return strb ? new_b : old_b;
  endfunction

endpackage

// File: rtl/gbuf_mem_array.sv
// gbuf_mem_array
//  Bare storage array for the global buffer: one write port with per-byte
//  enables, one synchronous read port, no reset, so it maps onto an SRAM macro.
//  The read register only updates on i_re, so o_rdata holds between reads.
// Ports
//  clk      in   clock
//  i_we     in   write enable
//  i_waddr  in   write word address (must be < DEPTH)
//  i_wstrb  in   byte enables for the write
//  i_wdata  in   write data
//  i_re     in   read enable
//  i_raddr  in   read word address (must be < DEPTH)
//  o_rdata  out  read data, one cycle after i_re
module gbuf_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Read-before-write on a same-address collision: the read sees the old word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (i_wstrb[k]) r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/global_buffer_dp.sv
// global_buffer_dp
//  Simple-dual-port global buffer between the DMA/host loader and the PE-array
//  feeders. After reset (INIT) and on clr_req (CLEAR) the array is zeroed one
//  word per cycle; accesses are only accepted in IDLE. Writes are byte-strobed,
//  reads return one cycle later with rd_valid. Addresses >= DEPTH are dropped
//  (write) or return zero (read) and raise a one-cycle err_oob.
//  Optional macro GBUF_BYPASS_EN: a same-cycle same-address read returns the
//  freshly written word (write-first); otherwise it returns the old word.
// Ports
//  clk, rst_n  clock, asynchronous active-low reset
//  clr_req     start a clear sweep (sampled in IDLE only)
//  busy        INIT or CLEAR sweep in progress
//  wr_en/wr_addr/wr_strb/wr_data   write port
//  rd_en/rd_addr                   read request
//  rd_data/rd_valid                read result, one cycle after rd_en
//  err_oob     out-of-range access pulse
module global_buffer_dp
  import gbuf_pkg::*;
#(
  parameter int DATA_W = GBUF_DATA_W,
  parameter int DEPTH  = GBUF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err_oob
);

  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  gbuf_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              w_idle, w_last;
  logic              w_wr_oob, w_rd_oob, w_wr_acc, w_rd_acc;
  logic              w_mem_we, w_mem_re;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [STRB_W-1:0] w_mem_wstrb;
  logic [DATA_W-1:0] w_mem_wdata, w_mem_q, w_rd_word;
  logic              r_rd_valid, r_err, r_rd_live;

  // ---------------- sweep FSM ----------------
  assign w_idle = (r_state == IDLE);
  assign w_last = (r_clr_cnt == LAST_A);
  assign busy   = !w_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    if (w_last)  w_state_nxt = IDLE;
      IDLE:    if (clr_req) w_state_nxt = CLEAR;
      CLEAR:   if (w_last)  w_state_nxt = IDLE;
      default:              w_state_nxt = INIT;
    endcase
  end

  // Counter only runs during a sweep and wraps to 0 on the last word,
  // so it is already 0 whenever the next sweep starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_clr_cnt <= '0;
    else if (!w_idle) r_clr_cnt <= w_last ? '0 : r_clr_cnt + ADDR_W'(1);
  end

  // ---------------- access qualification ----------------
  // Constant-false when DEPTH is a power of two; synthesis folds it away.
  assign w_wr_oob = ({1'b0, wr_addr} >= DEPTH_X);
  assign w_rd_oob = ({1'b0, rd_addr} >= DEPTH_X);
  assign w_wr_acc = w_idle && wr_en;
  assign w_rd_acc = w_idle && rd_en;

  // The sweep owns the write port while busy.
  assign w_mem_we    = busy || (w_wr_acc && !w_wr_oob);
  assign w_mem_waddr = busy ? r_clr_cnt : wr_addr;
  assign w_mem_wstrb = busy ? '1 : wr_strb;
  assign w_mem_wdata = busy ? '0 : wr_data;
  assign w_mem_re    = w_rd_acc && !w_rd_oob;

  gbuf_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .STRB_W (STRB_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wstrb (w_mem_wstrb),
    .i_wdata (w_mem_wdata),
    .i_re    (w_mem_re),
    .i_raddr (rd_addr),
    .o_rdata (w_mem_q)
  );

  // ---------------- read result ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      r_rd_live  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      r_err      <= (w_wr_acc && w_wr_oob) || (w_rd_acc && w_rd_oob);
      // Live = last accepted read hit the array. Cleared by reset and by an
      // out-of-range read, which forces rd_data to zero without an SRAM reset.
      if (w_rd_acc) r_rd_live <= !w_rd_oob;
    end
  end

`ifdef GBUF_BYPASS_EN
  // Same-address write captured alongside the read; its strobed bytes are
  // patched over the (old) SRAM word on the way out.
  logic              r_byp_hit;
  logic [STRB_W-1:0] r_byp_strb;
  logic [DATA_W-1:0] r_byp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byp_hit  <= 1'b0;
      r_byp_strb <= '0;
      r_byp_data <= '0;
    end else if (w_rd_acc) begin
      r_byp_hit  <= w_wr_acc && !w_wr_oob && !w_rd_oob && (wr_addr == rd_addr);
      r_byp_strb <= wr_strb;
      r_byp_data <= wr_data;
    end
  end

  always_comb begin
    w_rd_word = w_mem_q;
    for (int k = 0; k < STRB_W; k++) begin
      w_rd_word[8*k +: 8] = merge(w_mem_q[8*k +: 8], r_byp_data[8*k +: 8],
                                  r_byp_hit && r_byp_strb[k]);
    end
  end
`else
  assign w_rd_word = w_mem_q;
`endif

  // Every term here comes straight from a flop; no input-to-output path.
  assign rd_data  = r_rd_live ? w_rd_word : '0;
  assign rd_valid = r_rd_valid;
  assign err_oob  = r_err;

endmodule

// File: tb/tb_global_buffer_dp.sv
module tb_global_buffer_dp;

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [3:0]  ws;
    logic [31:0] wd;
    logic        re;
    logic [7:0]  ra;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

`ifdef GBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst_n, clr_req;
  logic        wr_en, rd_en;
  logic [7:0]  wr_addr, rd_addr;
  logic [3:0]  wr_strb;
  logic [31:0] wr_data;
  logic        busy, rd_valid, err_oob;
  logic [31:0] rd_data;
  logic        busy_b, rd_valid_b, err_oob_b;
  logic [31:0] rd_data_b;

  int n_err = 0;
  int n_chk = 0;

  global_buffer_dp #(.DATA_W(32), .DEPTH(256)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_strb(wr_strb), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .err_oob(err_oob)
  );

  // DEPTH=200 copy shares the stimulus; only its out-of-range behaviour is checked.
  global_buffer_dp #(.DATA_W(32), .DEPTH(200)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_strb(wr_strb), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .err_oob(err_oob_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    clr_req = 0; wr_en = 0; rd_en = 0;
    wr_addr = 0; rd_addr = 0; wr_strb = 0; wr_data = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Single read on the main DUT; returns valid and data seen one cycle later.
  task automatic rd1(input logic [7:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk); idle_in(); rd_en = 1; rd_addr = a;
    tick();
    chk({nm, " valid"}, {31'd0, rd_valid}, 32'd1);
    chk({nm, " data"}, rd_data, exp);
    @(negedge clk); idle_in();
  endtask

  // Posedges from now until busy drops (bounded); nb records the DEPTH=200 copy.
  task automatic count_busy(output int n, output int nb);
    n = 0; nb = 0;
    do begin
      tick(); n++;
      if (!busy_b && nb == 0) nb = n;
    end while ((busy || busy_b) && n < 1000);
  endtask

  vec_t        tbl[12];
  logic [31:0] model[256];
  int          n, nb, sp, nv;

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 32'd0;
    tbl[0]  = '{1'b1, 8'd5, 4'hF, 32'hDEADBEEF, 1'b0, 8'd0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 8'd5, 4'h5, 32'h11223344, 1'b0, 8'd0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 8'd0, 4'h0, 32'h0,        1'b1, 8'd5, 1'b1, 32'hDE22BE44};
    tbl[3]  = '{1'b0, 8'd0, 4'h0, 32'h0,        1'b0, 8'd0, 1'b0, 32'hDE22BE44};
    tbl[4]  = '{1'b1, 8'd9, 4'hF, 32'hA5A5A5A5, 1'b1, 8'd9, 1'b1,
                BYP ? 32'hA5A5A5A5 : 32'h0};
    tbl[5]  = '{1'b0, 8'd0, 4'h0, 32'h0,        1'b1, 8'd9, 1'b1, 32'hA5A5A5A5};
    tbl[6]  = '{1'b1, 8'd7, 4'h0, 32'hFFFFFFFF, 1'b1, 8'd7, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 8'd3, 4'h1, 32'h000000AA, 1'b1, 8'd5, 1'b1, 32'hDE22BE44};
    tbl[8]  = '{1'b0, 8'd0, 4'h0, 32'h0,        1'b1, 8'd3, 1'b1, 32'h000000AA};
    tbl[9]  = '{1'b1, 8'd5, 4'h2, 32'h00009900, 1'b1, 8'd5, 1'b1,
                BYP ? 32'hDE229944 : 32'hDE22BE44};
    tbl[10] = '{1'b0, 8'd0, 4'h0, 32'h0,        1'b1, 8'd5, 1'b1, 32'hDE229944};
    tbl[11] = '{1'b0, 8'd0, 4'h0, 32'h0,        1'b1, 8'd7, 1'b1, 32'h0};

    // ---- reset values ----
    idle_in();
    rst_n = 0;
    #3;
    chk("reset busy",     {31'd0, busy},     32'd1);
    chk("reset rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset rd_data",  rd_data,           32'd0);
    chk("reset err_oob",  {31'd0, err_oob},  32'd0);
    chk("reset busy_b",   {31'd0, busy_b},   32'd1);
    repeat (2) @(posedge clk);

    // ---- INIT sweep length ----
    @(negedge clk); rst_n = 1;
    count_busy(n, nb);
    chk("init busy cycles d256", n,  32'd256);
    chk("init busy cycles d200", nb, 32'd200);
    rd1(8'd0,   32'd0, "init rd 0");
    rd1(8'd128, 32'd0, "init rd 128");
    rd1(8'd255, 32'd0, "init rd 255");

    // ---- table: strobed writes, reads, collisions ----
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      idle_in();
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_strb = tbl[i].ws; wr_data = tbl[i].wd;
      rd_en = tbl[i].re; rd_addr = tbl[i].ra;
      if (tbl[i].we)
        for (int k = 0; k < 4; k++)
          if (tbl[i].ws[k]) model[tbl[i].wa][8*k +: 8] = tbl[i].wd[8*k +: 8];
      tick();
      chk($sformatf("vec%0d rd_valid", i), {31'd0, rd_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d rd_data", i),  rd_data,           tbl[i].ed);
      chk($sformatf("vec%0d err_oob", i),  {31'd0, err_oob},  32'd0);
    end

    // ---- back-to-back sweep read ----
    nv = 0;
    for (int a = 0; a <= 256; a++) begin
      @(negedge clk);
      idle_in();
      rd_en = (a < 256); rd_addr = a[7:0];
      tick();
      if (a < 256) begin
        if (rd_valid) nv++;
        chk($sformatf("b2b data %0d", a), rd_data, model[a]);
      end else begin
        chk("b2b valid after stop", {31'd0, rd_valid}, 32'd0);
      end
    end
    chk("b2b valid count", nv, 32'd256);

    // ---- out of range on DEPTH=200 ----
    @(negedge clk); idle_in();
    wr_en = 1; wr_addr = 8'd210; wr_strb = 4'hF; wr_data = 32'hFFFFFFFF;
    rd_en = 1; rd_addr = 8'd210;
    tick();
    chk("oob rd_valid", {31'd0, rd_valid_b}, 32'd1);
    chk("oob rd_data",  rd_data_b,           32'd0);
    chk("oob err",      {31'd0, err_oob_b},  32'd1);
    chk("in-range err d256", {31'd0, err_oob}, 32'd0);
    @(negedge clk); idle_in();
    tick();
    chk("oob err pulse end", {31'd0, err_oob_b},  32'd0);
    chk("oob data hold",     rd_data_b,           32'd0);
    chk("oob valid end",     {31'd0, rd_valid_b}, 32'd0);
    @(negedge clk); idle_in();
    wr_en = 1; wr_addr = 8'd220; wr_strb = 4'hF; wr_data = 32'h12345678;
    rd_en = 1; rd_addr = 8'd200;
    tick();
    chk("both oob err", {31'd0, err_oob_b}, 32'd1);
    @(negedge clk); idle_in();
    tick();
    chk("both oob err end", {31'd0, err_oob_b}, 32'd0);
    @(negedge clk); idle_in(); rd_en = 1; rd_addr = 8'd199;
    tick();
    chk("last word err",  {31'd0, err_oob_b}, 32'd0);
    chk("last word data", rd_data_b,          32'd0);
    @(negedge clk); idle_in(); rd_en = 1; rd_addr = 8'd5;
    tick();
    chk("d200 rd 5 data", rd_data_b, 32'hDE229944);
    @(negedge clk); idle_in();

    // ---- CLEAR sweep with ignored requests ----
    @(negedge clk); clr_req = 1;
    tick();
    chk("clear busy", {31'd0, busy}, 32'd1);
    n = 0; sp = 0;
    do begin
      @(negedge clk);
      clr_req = (n < 3); wr_en = (n < 3); rd_en = (n < 3);
      wr_addr = 8'd5; wr_strb = 4'hF; wr_data = 32'h12345678; rd_addr = 8'd5;
      tick(); n++;
      if (rd_valid || err_oob) sp++;
    end while (busy && n < 1000);
    chk("clear busy cycles", n, 32'd256);
    chk("clear spurious out", sp, 32'd0);
    @(negedge clk); idle_in();
    tick();
    chk("clear no restart", {31'd0, busy}, 32'd0);
    rd1(8'd5, 32'd0, "clear rd 5");
    rd1(8'd9, 32'd0, "clear rd 9");

    // ---- reset in the middle of a CLEAR sweep ----
    @(negedge clk); idle_in(); wr_en = 1; wr_addr = 8'd9; wr_strb = 4'hF; wr_data = 32'hA5A5A5A5;
    rd1(8'd9, 32'hA5A5A5A5, "pre-reset rd 9");
    @(negedge clk); clr_req = 1;
    tick();
    @(negedge clk); clr_req = 0;
    repeat (99) @(posedge clk);
    #1;
    chk("mid-sweep busy", {31'd0, busy}, 32'd1);
    chk("mid-sweep hold", rd_data, 32'hA5A5A5A5);
    @(negedge clk); rst_n = 0;
    #1;
    chk("mid reset busy",     {31'd0, busy},     32'd1);
    chk("mid reset rd_data",  rd_data,           32'd0);
    chk("mid reset rd_valid", {31'd0, rd_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    count_busy(n, nb);
    chk("re-init busy cycles", n, 32'd256);
    rd1(8'd9,   32'd0, "re-init rd 9");
    rd1(8'd5,   32'd0, "re-init rd 5");
    rd1(8'd255, 32'd0, "re-init rd 255");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
